// File: rtl/alu_wb_stage.sv
// Execute/writeback stage: registers ALU results into RF writes and PC redirects, and runs
// data-memory transactions for loads/stores through a small IDLE/REQ/RSP FSM.
module alu_wb_stage #(
  parameter int unsigned pc_width_p  = 10,
  parameter int unsigned imm_width_p = 8
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [31:0]           result_i,
  input  logic                  jump_now_i,
  input  logic [pc_width_p-1:0] pc_i,
  input  logic [imm_width_p-1:0] imm_i,
  input  logic [4:0]            rd_addr_i,
  input  logic [31:0]           store_data_i,
  input  logic                  is_branch_i,
  input  logic                  is_jalr_i,
  input  logic                  is_load_i,
  input  logic                  is_store_i,
  input  logic                  is_byte_i,
  input  logic                  writes_rf_i,
  output logic                  rf_wen_o,
  output logic [4:0]            rf_waddr_o,
  output logic [31:0]           rf_wdata_o,
  output logic                  redirect_v_o,
  output logic [pc_width_p-1:0] redirect_pc_o,
  output logic                  mem_v_o,
  output logic                  mem_w_o,
  output logic [29:0]           mem_addr_o,
  output logic [31:0]           mem_data_o,
  output logic [3:0]            mem_mask_o,
  input  logic                  mem_yumi_i,
  input  logic                  mem_rsp_v_i,
  input  logic [31:0]           mem_rsp_data_i
);

  typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

  state_e                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           sdata_q, sdata_d;
  logic [4:0]            rd_q, rd_d;
  logic                  st_q, st_d;
  logic                  byte_q, byte_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [4:0]            rf_waddr_q, rf_waddr_d;
  logic [31:0]           rf_wdata_q, rf_wdata_d;
  logic                  redirect_v_q, redirect_v_d;
  logic [pc_width_p-1:0] redirect_pc_q, redirect_pc_d;

  logic [pc_width_p-1:0] pc_plus1;
  logic [pc_width_p-1:0] imm_ext;
  logic [31:0]           rsp_byte;
  logic                  in_req;

  assign pc_plus1 = pc_i + pc_width_p'(1);
  assign imm_ext  = pc_width_p'($signed(imm_i));
  assign rsp_byte = {24'b0, mem_rsp_data_i[{addr_q[1:0], 3'b000} +: 8]};

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    sdata_d       = sdata_q;
    rd_d          = rd_q;
    st_d          = st_q;
    byte_d        = byte_q;
    rf_wen_d      = 1'b0;
    rf_waddr_d    = '0;
    rf_wdata_d    = '0;
    redirect_v_d  = 1'b0;
    redirect_pc_d = '0;
    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          if (is_load_i || is_store_i) begin
            addr_d  = result_i;
            sdata_d = store_data_i;
            rd_d    = rd_addr_i;
            st_d    = is_store_i;
            byte_d  = is_byte_i;
            state_d = StReq;
          end else if (is_branch_i) begin
            // jump_now_i is only meaningful for branches
            if (jump_now_i) begin
              redirect_v_d  = 1'b1;
              redirect_pc_d = pc_plus1 + imm_ext;
            end
          end else if (is_jalr_i) begin
            redirect_v_d  = 1'b1;
            redirect_pc_d = result_i[pc_width_p-1:0];
            if (writes_rf_i) begin
              rf_wen_d   = 1'b1;
              rf_waddr_d = rd_addr_i;
              rf_wdata_d = 32'(pc_plus1);
            end
          end else if (writes_rf_i) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = rd_addr_i;
            rf_wdata_d = result_i;
          end
        end
      end
      StReq: begin
        if (mem_yumi_i) state_d = st_q ? StIdle : StRsp;
      end
      StRsp: begin
        if (mem_rsp_v_i) begin
          rf_wen_d   = 1'b1;
          rf_waddr_d = rd_q;
          rf_wdata_d = byte_q ? rsp_byte : mem_rsp_data_i;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      sdata_q       <= '0;
      rd_q          <= '0;
      st_q          <= 1'b0;
      byte_q        <= 1'b0;
      rf_wen_q      <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      redirect_v_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      sdata_q       <= sdata_d;
      rd_q          <= rd_d;
      st_q          <= st_d;
      byte_q        <= byte_d;
      rf_wen_q      <= rf_wen_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      redirect_v_q  <= redirect_v_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Gated by n_reset so ready stays low while reset is held
  assign ready_o       = n_reset && (state_q == StIdle);
  assign rf_wen_o      = rf_wen_q;
  assign rf_waddr_o    = rf_waddr_q;
  assign rf_wdata_o    = rf_wdata_q;
  assign redirect_v_o  = redirect_v_q;
  assign redirect_pc_o = redirect_pc_q;

  assign in_req     = (state_q == StReq);
  assign mem_v_o    = in_req;
  assign mem_w_o    = in_req && st_q;
  assign mem_addr_o = in_req ? addr_q[31:2] : '0;

  always_comb begin
    mem_mask_o = 4'b0000;
    mem_data_o = '0;
    if (in_req) begin
      mem_mask_o = (st_q && byte_q) ? (4'b0001 << addr_q[1:0]) : 4'b1111;
      if (st_q) mem_data_o = byte_q ? {4{sdata_q[7:0]}} : sdata_q;
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: a scoreboard of expected RF/redirect strobes keyed
// by cycle, plus direct checks of the memory handshake.
module tb_alu_wb_stage;

  logic        clk;
  logic        n_reset;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] result_i;
  logic        jump_now_i;
  logic [9:0]  pc_i;
  logic [7:0]  imm_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] store_data_i;
  logic        is_branch_i, is_jalr_i, is_load_i, is_store_i, is_byte_i, writes_rf_i;
  logic        rf_wen_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        redirect_v_o;
  logic [9:0]  redirect_pc_o;
  logic        mem_v_o, mem_w_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_mask_o;
  logic        mem_yumi_i, mem_rsp_v_i;
  logic [31:0] mem_rsp_data_i;

  alu_wb_stage dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .result_i       (result_i),
    .jump_now_i     (jump_now_i),
    .pc_i           (pc_i),
    .imm_i          (imm_i),
    .rd_addr_i      (rd_addr_i),
    .store_data_i   (store_data_i),
    .is_branch_i    (is_branch_i),
    .is_jalr_i      (is_jalr_i),
    .is_load_i      (is_load_i),
    .is_store_i     (is_store_i),
    .is_byte_i      (is_byte_i),
    .writes_rf_i    (writes_rf_i),
    .rf_wen_o       (rf_wen_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .redirect_v_o   (redirect_v_o),
    .redirect_pc_o  (redirect_pc_o),
    .mem_v_o        (mem_v_o),
    .mem_w_o        (mem_w_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_mask_o     (mem_mask_o),
    .mem_yumi_i     (mem_yumi_i),
    .mem_rsp_v_i    (mem_rsp_v_i),
    .mem_rsp_data_i (mem_rsp_data_i)
  );

  typedef struct {
    int          cyc;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rv;
    logic [9:0]  rpc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Strobe monitor: scoreboard entry due this cycle, otherwise no strobe at all
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        mon_e = sb.pop_front();
        check("rf_wen", rf_wen_o, mon_e.wen);
        if (mon_e.wen) begin
          check("rf_waddr", rf_waddr_o, mon_e.wa);
          check("rf_wdata", rf_wdata_o, mon_e.wd);
        end
        check("redirect_v", redirect_v_o, mon_e.rv);
        if (mon_e.rv) check("redirect_pc", redirect_pc_o, mon_e.rpc);
      end else begin
        check("idle_rf_wen", rf_wen_o, 0);
        check("idle_redirect_v", redirect_v_o, 0);
      end
    end
  end

  // Call just after a rising edge with the stage idle; returns just after the accepting edge.
  task automatic send(input logic br, input logic jalr, input logic ld, input logic st,
                      input logic byt, input logic wr, input logic jmp, input logic [9:0] pc,
                      input logic [7:0] imm, input logic [4:0] rd, input logic [31:0] res,
                      input logic [31:0] sd);
    exp_t e;
    logic [9:0] p1;
    valid_i = 1'b1; is_branch_i = br; is_jalr_i = jalr; is_load_i = ld; is_store_i = st;
    is_byte_i = byt; writes_rf_i = wr; jump_now_i = jmp; pc_i = pc; imm_i = imm;
    rd_addr_i = rd; result_i = res; store_data_i = sd;
    check("ready_at_issue", ready_o, 1);
    if (!ld && !st) begin
      p1    = pc + 10'd1;
      e.cyc = cyc + 1;
      e.wa  = rd;
      e.wen = jalr ? wr : (!br && wr);
      e.wd  = jalr ? {22'b0, p1} : res;
      e.rv  = br ? jmp : jalr;
      e.rpc = br ? (p1 + {{2{imm[7]}}, imm}) : res[9:0];
      if (e.wen || e.rv) sb.push_back(e);
    end
    @(posedge clk); #1;
    valid_i = 1'b0; is_branch_i = 1'b0; is_jalr_i = 1'b0; is_load_i = 1'b0;
    is_store_i = 1'b0; is_byte_i = 1'b0; writes_rf_i = 1'b0;
  endtask

  task automatic mem_txn(input logic st, input logic byt, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] rd, input int yd,
                         input int lat, input logic [31:0] rsp);
    logic [3:0]  emask;
    logic [31:0] edata;
    logic [31:0] sh;
    exp_t        e;
    emask = (st && byt) ? (4'b0001 << addr[1:0]) : 4'b1111;
    edata = byt ? {4{sdata[7:0]}} : sdata;
    send(1'b0, 1'b0, !st, st, byt, !st, 1'b0, 10'h0, 8'h0, rd, addr, sdata);
    for (int i = 0; i <= yd; i++) begin
      if (i == yd) begin
        // Response in the yumi cycle must be ignored
        mem_yumi_i = 1'b1; mem_rsp_v_i = 1'b1; mem_rsp_data_i = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      check("mem_v", mem_v_o, 1);
      check("mem_w", mem_w_o, st);
      check("mem_addr", mem_addr_o, addr[31:2]);
      check("mem_mask", mem_mask_o, emask);
      if (st) check("mem_data", mem_data_o, edata);
      check("ready_in_req", ready_o, 0);
      @(posedge clk); #1;
      mem_yumi_i = 1'b0; mem_rsp_v_i = 1'b0;
    end
    if (st) begin
      check("store_done_ready", ready_o, 1);
      check("store_done_mem_v", mem_v_o, 0);
    end else begin
      for (int j = 1; j <= lat; j++) begin
        if (j == lat) begin
          mem_rsp_v_i = 1'b1; mem_rsp_data_i = rsp;
          sh    = rsp >> {addr[1:0], 3'b000};
          e.cyc = cyc + 1; e.wen = 1'b1; e.wa = rd;
          e.wd  = byt ? {24'b0, sh[7:0]} : rsp;
          e.rv  = 1'b0; e.rpc = '0;
          sb.push_back(e);
        end
        @(negedge clk);
        check("ready_in_rsp", ready_o, 0);
        check("mem_v_in_rsp", mem_v_o, 0);
        @(posedge clk); #1;
        mem_rsp_v_i = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_reset = 1'b0; valid_i = 1'b0; result_i = '0; jump_now_i = 1'b0; pc_i = '0;
    imm_i = '0; rd_addr_i = '0; store_data_i = '0; is_branch_i = 1'b0; is_jalr_i = 1'b0;
    is_load_i = 1'b0; is_store_i = 1'b0; is_byte_i = 1'b0; writes_rf_i = 1'b0;
    mem_yumi_i = 1'b0; mem_rsp_v_i = 1'b0; mem_rsp_data_i = '0;
    #2;
    check("rst_ready", ready_o, 0);
    check("rst_rf_wen", rf_wen_o, 0);
    check("rst_redirect_v", redirect_v_o, 0);
    check("rst_mem_v", mem_v_o, 0);
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", ready_o, 1);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // ADDU then back-to-back not-taken BEQZ, with stray yumi/rsp in IDLE
    send(0, 0, 0, 0, 0, 1, 0, 10'h010, 8'h00, 5'd3, 32'h0000_0007, 32'h0);
    mem_yumi_i = 1'b1; mem_rsp_v_i = 1'b1;
    send(1, 0, 0, 0, 0, 0, 0, 10'h011, 8'h05, 5'd0, 32'h0, 32'h0);
    mem_yumi_i = 1'b0; mem_rsp_v_i = 1'b0;

    // Taken branches (negative offset, wrap) and JALR with link
    send(1, 0, 0, 0, 0, 0, 1, 10'h3FE, 8'hFC, 5'd0, 32'h0, 32'h0);
    send(1, 0, 0, 0, 0, 0, 1, 10'h3FF, 8'h01, 5'd0, 32'h0, 32'h0);
    send(0, 1, 0, 0, 0, 1, 0, 10'h005, 8'h00, 5'd1, 32'h0000_0120, 32'h0);

    for (int k = 0; k < 4; k++)
      send(0, 0, 0, 0, 0, 1, 0, 10'($urandom), 8'h00, 5'($urandom_range(31)), $urandom, 32'h0);

    // LBU with delayed yumi and response, then issue in the write-back cycle
    mem_txn(0, 1, 32'h0000_0013, 32'h0, 5'd7, 3, 2, 32'hAABB_CCDD);
    send(0, 0, 0, 0, 0, 1, 0, 10'h020, 8'h00, 5'd0, 32'h1234_0000, 32'h0);

    mem_txn(1, 1, 32'h0000_0021, 32'h0000_005A, 5'd0, 0, 1, 32'h0);
    mem_txn(1, 0, 32'h0000_0040, 32'hDEAD_BEEF, 5'd0, 1, 1, 32'h0);
    mem_txn(0, 0, 32'h0000_0088, 32'h0, 5'd31, 0, 1, 32'h1234_5678);
    mem_txn(0, 1, 32'h0000_0046, 32'h0, 5'd9, 0, 3, 32'h1122_3344);

    // Reset in the middle of a load request
    send(0, 0, 1, 0, 0, 1, 0, 10'h0, 8'h00, 5'd4, 32'h0000_0100, 32'h0);
    @(negedge clk);
    check("pre_rst_mem_v", mem_v_o, 1);
    #2 n_reset = 1'b0; mon_en = 1'b0;
    #1;
    check("mid_rst_mem_v", mem_v_o, 0);
    check("mid_rst_mem_w", mem_w_o, 0);
    check("mid_rst_mem_addr", mem_addr_o, 0);
    check("mid_rst_mem_mask", mem_mask_o, 0);
    check("mid_rst_mem_data", mem_data_o, 0);
    check("mid_rst_rf_wen", rf_wen_o, 0);
    check("mid_rst_redirect_v", redirect_v_o, 0);
    check("mid_rst_ready", ready_o, 0);
    @(posedge clk); #1 n_reset = 1'b1;
    @(negedge clk);
    check("rerst_ready", ready_o, 1);
    @(posedge clk); #1;
    mon_en = 1'b1;
    // A late response for the discarded load must not write back
    mem_rsp_v_i = 1'b1; mem_rsp_data_i = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_rsp_v_i = 1'b0;
    send(0, 0, 0, 0, 0, 1, 0, 10'h033, 8'h00, 5'd12, 32'h0BAD_CAFE, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_wb_stage.md
# alu_wb_stage

Execute/writeback stage that consumes the ALU's `result` and `jump_now` outputs and turns them into register-file writes, data-memory transactions, and PC redirects. It sits between the combinational ALU and the register file, data memory and fetch unit, and is the receiving end of the ALU output interface. It adds one registered stage and a small FSM that stalls the core during memory accesses.

## Interface
- `pc_width_p`, default 10: width of the word-addressed instruction PC.
- `imm_width_p`, default 8: width of the signed branch offset.
- `clk` in 1: core clock; all state updates on its rising edge.
- `n_reset` in 1: asynchronous, active-low reset.
- `valid_i` in 1: the ALU outputs and decode fields below are valid this cycle.
- `ready_o` out 1: the stage accepts the instruction this cycle. An instruction transfers when `valid_i && ready_o`.
- `result_i` in 32: ALU `result`. Holds the write data, or the memory address for LW/LBU/SW/SB, or the target for JALR.
- `jump_now_i` in 1: ALU branch decision. Sampled only when `is_branch_i` is 1, because it is X otherwise.
- `pc_i` in `pc_width_p`: PC of the instruction.
- `imm_i` in `imm_width_p`: signed branch offset.
- `rd_addr_i` in 5: destination register.
- `store_data_i` in 32: data for a store.
- `is_branch_i`, `is_jalr_i`, `is_load_i`, `is_store_i`, `is_byte_i`, `writes_rf_i` in 1 each: decoded instruction class. At most one of branch, jalr, load, store is set.
- `rf_wen_o` out 1: register-file write strobe.
- `rf_waddr_o` out 5: register-file write address.
- `rf_wdata_o` out 32: register-file write data.
- `redirect_v_o` out 1: fetch redirect strobe.
- `redirect_pc_o` out `pc_width_p`: redirect target.
- `mem_v_o` out 1: data-memory request valid.
- `mem_w_o` out 1: the request is a write.
- `mem_addr_o` out 30: word address.
- `mem_data_o` out 32: write data.
- `mem_mask_o` out 4: byte-enable mask.
- `mem_yumi_i` in 1: memory accepts the request this cycle.
- `mem_rsp_v_i` in 1: load response is valid this cycle.
- `mem_rsp_data_i` in 32: load response word.

## Operation
- **FSM states:** IDLE, REQ, RSP. `ready_o` is 1 only in IDLE.
- **IDLE, accepted non-memory instruction:** the next cycle carries exactly one strobe pulse, then the FSM stays in IDLE.
  - ALU op with `writes_rf_i`: `rf_wen_o`=1, `rf_waddr_o`=`rd_addr_i`, `rf_wdata_o`=`result_i`.
  - Branch with `jump_now_i`=1: `redirect_v_o`=1, `redirect_pc_o`=`pc_i`+1+sext(`imm_i`), truncated to `pc_width_p`. A not-taken branch produces no strobe.
  - JALR: `redirect_v_o`=1 and `redirect_pc_o`=`result_i[pc_width_p-1:0]`. If `writes_rf_i`, it also writes `rd` with zero-extended `pc_i`+1 in the same cycle.
- **Writes to r0:** these are performed. Suppressing them is the register file's job.
- **IDLE, accepted load or store:** the stage latches its fields and goes to REQ.
- **REQ:** the stage drives the memory request until acceptance.
  - `mem_v_o`=1, `mem_addr_o`=`result_i[31:2]`.
  - Store: `mem_w_o`=1. SW uses `mem_mask_o`=4'b1111 and `mem_data_o`=`store_data_i`. SB uses `mem_mask_o`=1<<`result_i[1:0]` and `store_data_i[7:0]` replicated into all four lanes.
  - Load: `mem_w_o`=0, `mem_mask_o`=4'b1111.
  - On `mem_yumi_i`: a store returns to IDLE and a load goes to RSP.
- **RSP:** the stage waits for `mem_rsp_v_i`, then for one cycle drives `rf_wen_o`=1 to `rd` and returns to IDLE.
  - LW writes the full response word.
  - LBU writes the byte selected by the latched `result_i[1:0]`, zero-extended.
- **Illegal inputs:** a `mem_rsp_v_i` arriving outside RSP is ignored. A `mem_yumi_i` arriving outside REQ is ignored.

## Timing
- **Reset:** every output is 0 and the FSM is in IDLE. With `n_reset` asserted, `ready_o` is 0; after release, `ready_o` is 1 (IDLE).
- **Reset mid-transaction:** `mem_v_o` drops immediately (asynchronously) and the pending load is discarded.
- **ALU, branch and JALR latency:** 1 cycle from acceptance to strobe. Back-to-back issue is allowed, one instruction per cycle.
- **Stores:** occupancy is 1 cycle plus the wait for `mem_yumi_i`. `mem_v_o` rises the cycle after acceptance, and all memory outputs hold stable until `mem_yumi_i`.
- **Loads:** REQ cycles, then RSP cycles, then the write-back strobe on the cycle after `mem_rsp_v_i`.
  - The earliest the next instruction can be accepted is the cycle of the write-back strobe.
  - A response arriving in the same cycle as `mem_yumi_i` is not sampled; the minimum response latency is 1 cycle.
- **Strobes:** `rf_wen_o` and `redirect_v_o` are single-cycle pulses and are 0 in every other cycle.

## Test plan
- **Reset:** assert `n_reset`=0 mid-REQ. Required: all outputs are 0 immediately and `ready_o`=1 one cycle after release.
- **ALU write-back:** ADDU `result_i`=0x0000_0007, `rd`=3. Required: the next cycle has `rf_wen_o`=1, `rf_waddr_o`=3, `rf_wdata_o`=7. Follow it back-to-back with a not-taken BEQZ: no strobes.
- **Branches and JALR:**
  - BNEQZ taken with `pc_i`=0x3FE, `imm_i`=8'hFC. Required: `redirect_pc_o`=0x3FB.
  - BNEQZ taken with `pc_i`=0x3FF, `imm_i`=1. Required: wrap to 0x001.
  - JALR with `result_i`=0x120, `pc_i`=5. Required: redirect to 0x120 and `rf_wdata_o`=6 in the same cycle.
- **LBU:** address 0x0000_0013, `mem_yumi_i` delayed 3 cycles, response 0xAABBCCDD after 2 more cycles. Required: `mem_addr_o`=0x4 held for all 4 REQ cycles and `rf_wdata_o`=0x0000_00AA.
- **SB:** address 0x0000_0021, data 0x0000_005A, `mem_yumi_i` immediate. Required: `mem_mask_o`=4'b0010, `mem_data_o`=0x5A5A5A5A, and `ready_o` back to 1 the next cycle.
